// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_access
// Purpose  : Load/store stage between EXE_MEM and MEM_WB. ALU results pass
//            straight through; loads and stores run a req/ack transaction to
//            data memory while stalling the upstream pipeline, and load data
//            is lane-extracted and sign/zero-extended before reaching MEM_WB.
// Ports    :
//   clk_i_MEM_ACC / rst_i_MEM_ACC    stage clock, async active-low reset
//   Wt_Data/Addr/Enable_i_MEM_ACC    ALU result (effective address), rd, we
//   Mem_Rd/Wr/Funct3_i_MEM_ACC       load/store flags and access size/sign
//   St_Data_i_MEM_ACC                store data (rs2)
//   Dmem_*                           data-memory request/acknowledge bus
//   Wt_Data/Addr/Enable_o_MEM_ACC    result to MEM_WB
//   Stall_o_MEM_ACC                  hold PC, IF_ID, ID_EXE and EXE_MEM
//   Misalign_o_MEM_ACC               misaligned-access pulse
//   Bus_Err_o_MEM_ACC                ack-timeout pulse
// Revision : 1.0 - initial release
// ============================================================================
module mem_access #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk_i_MEM_ACC,
    input  logic        rst_i_MEM_ACC,
    input  logic [31:0] Wt_Data_i_MEM_ACC,
    input  logic [4:0]  Wt_Addr_i_MEM_ACC,
    input  logic        Wt_Enable_i_MEM_ACC,
    input  logic        Mem_Rd_i_MEM_ACC,
    input  logic        Mem_Wr_i_MEM_ACC,
    input  logic [2:0]  Mem_Funct3_i_MEM_ACC,
    input  logic [31:0] St_Data_i_MEM_ACC,
    output logic        Dmem_Req_o,
    output logic        Dmem_We_o,
    output logic [31:0] Dmem_Addr_o,
    output logic [3:0]  Dmem_Be_o,
    output logic [31:0] Dmem_Wdata_o,
    input  logic [31:0] Dmem_Rdata_i,
    input  logic        Dmem_Ack_i,
    output logic [31:0] Wt_Data_o_MEM_ACC,
    output logic [4:0]  Wt_Addr_o_MEM_ACC,
    output logic        Wt_Enable_o_MEM_ACC,
    output logic        Stall_o_MEM_ACC,
    output logic        Misalign_o_MEM_ACC,
    output logic        Bus_Err_o_MEM_ACC
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT_CYC);

    // ------------------------------------------------------------------
    // State and latched transaction
    // ------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic [31:0] r_addr;
    logic [2:0]  r_funct3;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [4:0]  r_wt_addr;
    logic        r_wt_en;
    logic [31:0] r_ld_data;
    logic        r_bus_err;

    // ------------------------------------------------------------------
    // Request decode from the incoming instruction
    // ------------------------------------------------------------------
    logic        w_mem_op;
    logic        w_in_byte;
    logic        w_in_half;
    logic        w_misalign;
    logic        w_idle;
    logic        w_busy;
    logic        w_start;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    assign w_mem_op  = Mem_Rd_i_MEM_ACC | Mem_Wr_i_MEM_ACC;
    // Funct3[1:0]: 00 byte, 01 half, anything else is treated as a word.
    assign w_in_byte = (Mem_Funct3_i_MEM_ACC[1:0] == 2'b00);
    assign w_in_half = (Mem_Funct3_i_MEM_ACC[1:0] == 2'b01);

    assign w_misalign = w_in_half ? Wt_Data_i_MEM_ACC[0]
                      : w_in_byte ? 1'b0
                      : (Wt_Data_i_MEM_ACC[1:0] != 2'b00);

    assign w_idle  = (r_state == c_ST_IDLE);
    assign w_busy  = (r_state == c_ST_BUSY);
    // Reset gating keeps the combinational stall/misalign paths quiet while
    // the stage is held in reset with a memory op sitting on its inputs.
    assign w_start = rst_i_MEM_ACC & w_idle & w_mem_op & ~w_misalign;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = St_Data_i_MEM_ACC;
        if (w_in_byte) begin
            w_be    = 4'b0001 << Wt_Data_i_MEM_ACC[1:0];
            w_wdata = {4{St_Data_i_MEM_ACC[7:0]}};
        end else if (w_in_half) begin
            w_be    = 4'b0011 << Wt_Data_i_MEM_ACC[1:0];
            w_wdata = {2{St_Data_i_MEM_ACC[15:0]}};
        end
    end

    // ------------------------------------------------------------------
    // Load data alignment and extension, using the latched access info
    // ------------------------------------------------------------------
    logic [31:0] w_rd_shift;
    logic [31:0] w_ld_data;

    assign w_rd_shift = Dmem_Rdata_i >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_ld_data = Dmem_Rdata_i;
        case (r_funct3)
            3'b000:  w_ld_data = {{24{w_rd_shift[7]}},  w_rd_shift[7:0]};
            3'b001:  w_ld_data = {{16{w_rd_shift[15]}}, w_rd_shift[15:0]};
            3'b100:  w_ld_data = {24'd0, w_rd_shift[7:0]};
            3'b101:  w_ld_data = {16'd0, w_rd_shift[15:0]};
            default: w_ld_data = Dmem_Rdata_i;
        endcase
    end

    // ------------------------------------------------------------------
    // Timeout: the counter holds the number of BUSY cycles already spent
    // without an ack; reaching TIMEOUT_CYC ends the access with an error.
    // ------------------------------------------------------------------
    logic [7:0] w_cnt_next;
    logic       w_timeout;

    assign w_cnt_next = r_cnt + 8'd1;
    assign w_timeout  = (w_cnt_next == c_TIMEOUT);

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i_MEM_ACC or negedge rst_i_MEM_ACC) begin
        if (!rst_i_MEM_ACC) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= 8'd0;
            r_addr    <= 32'd0;
            r_funct3  <= 3'd0;
            r_we      <= 1'b0;
            r_be      <= 4'd0;
            r_wdata   <= 32'd0;
            r_wt_addr <= 5'd0;
            r_wt_en   <= 1'b0;
            r_ld_data <= 32'd0;
            r_bus_err <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_start) begin
                        r_addr    <= Wt_Data_i_MEM_ACC;
                        r_funct3  <= Mem_Funct3_i_MEM_ACC;
                        r_we      <= Mem_Wr_i_MEM_ACC;
                        r_be      <= w_be;
                        r_wdata   <= w_wdata;
                        r_wt_addr <= Wt_Addr_i_MEM_ACC;
                        r_wt_en   <= Wt_Enable_i_MEM_ACC;
                        r_cnt     <= 8'd0;
                        r_bus_err <= 1'b0;
                        r_state   <= c_ST_BUSY;
                    end
                end
                c_ST_BUSY: begin
                    r_cnt <= w_cnt_next;
                    // An ack arriving on the timeout cycle still completes.
                    if (Dmem_Ack_i) begin
                        r_ld_data <= w_ld_data;
                        r_state   <= c_ST_DONE;
                    end else if (w_timeout) begin
                        r_bus_err <= 1'b1;
                        r_state   <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    r_bus_err <= 1'b0;
                    r_state   <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Memory bus: driven only while the access is outstanding, so an
    // asynchronous reset drops the request without waiting for a clock.
    // ------------------------------------------------------------------
    assign Dmem_Req_o   = w_busy;
    assign Dmem_We_o    = w_busy & r_we;
    assign Dmem_Addr_o  = w_busy ? {r_addr[31:2], 2'b00} : 32'd0;
    assign Dmem_Be_o    = w_busy ? r_be : 4'd0;
    assign Dmem_Wdata_o = w_busy ? r_wdata : 32'd0;

    // ------------------------------------------------------------------
    // Pipeline-side outputs
    // ------------------------------------------------------------------
    assign Stall_o_MEM_ACC    = w_busy | w_start;
    assign Misalign_o_MEM_ACC = rst_i_MEM_ACC & w_idle & w_mem_op & w_misalign;
    assign Bus_Err_o_MEM_ACC  = (r_state == c_ST_DONE) & r_bus_err;

    always_comb begin
        Wt_Data_o_MEM_ACC   = 32'd0;
        Wt_Addr_o_MEM_ACC   = 5'd0;
        Wt_Enable_o_MEM_ACC = 1'b0;
        if (rst_i_MEM_ACC) begin
            case (r_state)
                c_ST_IDLE: begin
                    // Memory ops (aligned or not) present a bubble while in IDLE.
                    Wt_Data_o_MEM_ACC   = Wt_Data_i_MEM_ACC;
                    Wt_Addr_o_MEM_ACC   = Wt_Addr_i_MEM_ACC;
                    Wt_Enable_o_MEM_ACC = Wt_Enable_i_MEM_ACC & ~w_mem_op;
                end
                c_ST_BUSY: begin
                    Wt_Addr_o_MEM_ACC   = r_wt_addr;
                end
                c_ST_DONE: begin
                    Wt_Data_o_MEM_ACC   = r_ld_data;
                    Wt_Addr_o_MEM_ACC   = r_wt_addr;
                    Wt_Enable_o_MEM_ACC = r_wt_en & ~r_we & ~r_bus_err;
                end
                default: begin
                    Wt_Enable_o_MEM_ACC = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access
// Purpose  : Self-checking bench for mem_access. Directed cases followed by
//            randomized ALU/load/store traffic, each checked against an
//            arithmetic reference model of the access rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access;

    localparam int c_TO = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] wt_data_i;
    logic [4:0]  wt_addr_i;
    logic        wt_en_i;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  funct3;
    logic [31:0] st_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic [31:0] wt_data_o;
    logic [4:0]  wt_addr_o;
    logic        wt_en_o;
    logic        stall;
    logic        misalign;
    logic        bus_err;

    int n_cmp = 0;
    int n_err = 0;

    mem_access #(.TIMEOUT_CYC(c_TO)) dut (
        .clk_i_MEM_ACC        (clk),
        .rst_i_MEM_ACC        (rst_n),
        .Wt_Data_i_MEM_ACC    (wt_data_i),
        .Wt_Addr_i_MEM_ACC    (wt_addr_i),
        .Wt_Enable_i_MEM_ACC  (wt_en_i),
        .Mem_Rd_i_MEM_ACC     (mem_rd),
        .Mem_Wr_i_MEM_ACC     (mem_wr),
        .Mem_Funct3_i_MEM_ACC (funct3),
        .St_Data_i_MEM_ACC    (st_data),
        .Dmem_Req_o           (dmem_req),
        .Dmem_We_o            (dmem_we),
        .Dmem_Addr_o          (dmem_addr),
        .Dmem_Be_o            (dmem_be),
        .Dmem_Wdata_o         (dmem_wdata),
        .Dmem_Rdata_i         (dmem_rdata),
        .Dmem_Ack_i           (dmem_ack),
        .Wt_Data_o_MEM_ACC    (wt_data_o),
        .Wt_Addr_o_MEM_ACC    (wt_addr_o),
        .Wt_Enable_o_MEM_ACC  (wt_en_o),
        .Stall_o_MEM_ACC      (stall),
        .Misalign_o_MEM_ACC   (misalign),
        .Bus_Err_o_MEM_ACC    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model (access rules as arithmetic) ----------
    function automatic int acc_size(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off,
                                             input logic [31:0] w);
        logic [31:0] v;
        int sz;
        sz = acc_size(f3);
        if (sz == 4) return w;
        if (sz == 1) begin
            v = (w >> (8 * off)) % 256;
            if (f3 == 3'd0 && v >= 128) v = v - 256;
        end else begin
            v = (w >> (8 * off)) % 65536;
            if (f3 == 3'd1 && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_be(input logic [2:0] f3, input int off);
        int sz;
        sz = acc_size(f3);
        if (sz == 1) return 32'(1 << off);
        if (sz == 2) return 32'(3 << off);
        return 32'd15;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] st);
        int sz;
        sz = acc_size(f3);
        if (sz == 1) return (st % 256) * 32'h0101_0101;
        if (sz == 2) return (st % 65536) * 32'h0001_0001;
        return st;
    endfunction

    // ---------------- stimulus tasks ----------------------------------------
    task automatic do_alu(input logic [31:0] d, input logic [4:0] a, input logic en);
        @(posedge clk); #1;
        wt_data_i = d; wt_addr_i = a; wt_en_i = en;
        mem_rd = 1'b0; mem_wr = 1'b0;
        funct3 = 3'($urandom_range(0, 7)); st_data = $urandom;
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("alu_data",  wt_data_o, d);
        chk("alu_addr",  32'(wt_addr_o), 32'(a));
        chk("alu_en",    32'(wt_en_o), 32'(en));
        chk("alu_stall", 32'(stall), 32'd0);
        chk("alu_req",   32'(dmem_req), 32'd0);
        chk("alu_mis",   32'(misalign), 32'd0);
        chk("alu_berr",  32'(bus_err), 32'd0);
    endtask

    // n_ack: number of BUSY cycles before the ack; n_ack >= c_TO means no ack.
    task automatic do_mem(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] st, input logic [31:0] rword, input int n_ack,
                          input logic [4:0] rd_addr, input logic en);
        int off, sz, stall_n, busy_n, exp_busy;
        logic mis, done, tmo;
        off = int'(addr % 4);
        sz  = acc_size(f3);
        mis = (sz == 2 && (off % 2) != 0) || (sz == 4 && off != 0);
        tmo = (n_ack >= c_TO);
        @(posedge clk); #1;
        wt_data_i = addr; wt_addr_i = rd_addr; wt_en_i = en;
        mem_rd = ~wr; mem_wr = wr; funct3 = f3; st_data = st;
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("m0_mis",   32'(misalign), 32'(mis));
        chk("m0_stall", 32'(stall), 32'(!mis));
        chk("m0_req",   32'(dmem_req), 32'd0);
        chk("m0_berr",  32'(bus_err), 32'd0);
        if (mis) begin
            chk("mis_en", 32'(wt_en_o), 32'd0);
            return;
        end
        stall_n = 1;
        busy_n  = 0;
        done    = 1'b0;
        for (int b = 0; b < c_TO + 2 && !done; b++) begin
            @(posedge clk); #1;
            dmem_ack   = (b == n_ack);
            dmem_rdata = (b == n_ack) ? rword : $urandom;
            @(negedge clk);
            if (dmem_req) begin
                busy_n++;
                stall_n += int'(stall);
                if (b == 0) begin
                    chk("bus_we",   32'(dmem_we), 32'(wr));
                    chk("bus_addr", dmem_addr, addr - 32'(off));
                    chk("bus_be",   32'(dmem_be), ref_be(f3, off));
                    if (wr) chk("bus_wdata", dmem_wdata, ref_wdata(f3, st));
                end
            end else begin
                done = 1'b1;
            end
        end
        chk("done_reached", 32'(done), 32'd1);
        if (done) begin
            exp_busy = tmo ? c_TO : n_ack + 1;
            chk("busy_cycles", 32'(busy_n), 32'(exp_busy));
            chk("stall_total", 32'(stall_n), 32'(exp_busy + 1));
            chk("done_stall",  32'(stall), 32'd0);
            chk("done_berr",   32'(bus_err), 32'(tmo));
            chk("done_en",     32'(wt_en_o), 32'(!wr && en && !tmo));
            chk("done_waddr",  32'(wt_addr_o), 32'(rd_addr));
            if (!wr && !tmo) chk("done_ldata", wt_data_o, ref_load(f3, off, rword));
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  f;
        rst_n = 1'b0;
        wt_data_i = 32'hDEAD_BEEF; wt_addr_i = 5'd7; wt_en_i = 1'b1;
        mem_rd = 1'b1; mem_wr = 1'b0; funct3 = 3'b010; st_data = 32'h1111_2222;
        dmem_rdata = 32'd0; dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req",   32'(dmem_req), 32'd0);
        chk("rst_we",    32'(dmem_we), 32'd0);
        chk("rst_be",    32'(dmem_be), 32'd0);
        chk("rst_addr",  dmem_addr, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mis",   32'(misalign), 32'd0);
        chk("rst_berr",  32'(bus_err), 32'd0);
        chk("rst_wdat",  wt_data_o, 32'd0);
        chk("rst_wadr",  32'(wt_addr_o), 32'd0);
        chk("rst_wen",   32'(wt_en_o), 32'd0);
        mem_rd = 1'b0;
        rst_n = 1'b1;

        // Directed cases
        do_alu(32'h1234_5678, 5'd5, 1'b1);
        do_mem(1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_0000, 3, 5'd9, 1'b1);  // LB
        do_mem(1'b0, 3'b101, 32'h0000_0102, 32'd0, 32'h8001_0000, 0, 5'd10, 1'b1); // LHU
        do_mem(1'b1, 3'b001, 32'h0000_0102, 32'hAAAA_BEEF, 32'd0, 0, 5'd11, 1'b1);  // SH
        do_mem(1'b0, 3'b010, 32'h0000_0101, 32'd0, 32'd0, 0, 5'd12, 1'b1);          // LW misaligned
        do_mem(1'b0, 3'b010, 32'h0000_0200, 32'd0, 32'h1234_5678, 99, 5'd13, 1'b1); // timeout
        do_alu(32'hCAFE_F00D, 5'd14, 1'b1);
        do_mem(1'b0, 3'b010, 32'h0000_0300, 32'd0, 32'h0BAD_F00D, c_TO - 1, 5'd15, 1'b1); // ack on last cycle

        // Reset pulled low on BUSY cycle 2
        @(posedge clk); #1;
        wt_data_i = 32'h0000_0400; wt_addr_i = 5'd3; wt_en_i = 1'b1;
        mem_rd = 1'b1; mem_wr = 1'b0; funct3 = 3'b010; dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("pre_rst_req", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_req",   32'(dmem_req), 32'd0);
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_wen",   32'(wt_en_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rd = 1'b0;
        wt_data_i = 32'h5555_AAAA; wt_addr_i = 5'd4;
        @(posedge clk); #1;
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("late_ack_req",   32'(dmem_req), 32'd0);
        chk("late_ack_stall", 32'(stall), 32'd0);
        chk("late_ack_data",  wt_data_o, 32'h5555_AAAA);
        do_alu(32'h0F0F_0F0F, 5'd6, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_alu($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            end else begin
                f = 3'($urandom_range(0, 7));
                a = $urandom;
                if ($urandom_range(0, 1) == 1) begin
                    if (acc_size(f) == 2) a = a - (a % 2);
                    if (acc_size(f) == 4) a = a - (a % 4);
                end
                do_mem(1'($urandom_range(0, 1)), f, a, $urandom, $urandom,
                       int'($urandom_range(0, c_TO + 1)), 5'($urandom_range(0, 31)),
                       1'($urandom_range(0, 1)));
            end
        end
        do_alu(32'h8765_4321, 5'd31, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access.md
# mem_access

Load/store stage between the EXE_MEM register and the MEM_WB register. It forwards ALU results unchanged for non-memory instructions. For loads and stores it runs a request/acknowledge transaction to data memory, holds the upstream pipeline while the access is outstanding, and aligns and sign-extends load data. Its Wt_* outputs feed MEM_WB directly.

## Interface
Parameters:
- TIMEOUT_CYC, default 255: maximum cycles in BUSY waiting for Dmem_Ack_i before a bus error is raised (1..255).

Ports:
- clk_i_MEM_ACC  in  1  stage clock; all state changes on the rising edge.
- rst_i_MEM_ACC  in  1  reset, asynchronous, active-low.
- Wt_Data_i_MEM_ACC  in  32  ALU result; this is the effective address for loads and stores.
- Wt_Addr_i_MEM_ACC  in  5  destination register.
- Wt_Enable_i_MEM_ACC  in  1  register write enable.
- Mem_Rd_i_MEM_ACC  in  1  instruction is a load.
- Mem_Wr_i_MEM_ACC  in  1  instruction is a store. Never high together with Mem_Rd.
- Mem_Funct3_i_MEM_ACC  in  3  access size and sign: 000 byte, 001 half, 010 word, 100 unsigned byte, 101 unsigned half.
- St_Data_i_MEM_ACC  in  32  store data (rs2).
- Dmem_Req_o  out  1  memory request.
- Dmem_We_o  out  1  1 = write.
- Dmem_Addr_o  out  32  word address, {addr[31:2],2'b00}.
- Dmem_Be_o  out  4  byte enables.
- Dmem_Wdata_o  out  32  lane-aligned write data.
- Dmem_Rdata_i  in  32  read word; valid only while Dmem_Ack_i is high.
- Dmem_Ack_i  in  1  single-cycle completion pulse.
- Wt_Data_o_MEM_ACC  out  32  result to MEM_WB.
- Wt_Addr_o_MEM_ACC  out  5  destination register to MEM_WB.
- Wt_Enable_o_MEM_ACC  out  1  write enable to MEM_WB.
- Stall_o_MEM_ACC  out  1  hold PC, IF_ID, ID_EXE and EXE_MEM.
- Misalign_o_MEM_ACC  out  1  misaligned-access pulse.
- Bus_Err_o_MEM_ACC  out  1  timeout pulse.

## Operation
- State machine with three states: IDLE, BUSY, DONE.
- IDLE with no memory op:
  - Wt_* outputs equal the Wt_* inputs combinationally.
  - Stall_o is 0.
- IDLE with a memory op that is misaligned (half access with addr[0]=1, or word access with addr[1:0]≠0):
  - No request is issued.
  - Misalign_o is 1 combinationally.
  - Wt_Enable_o is 0.
  - Stall_o is 0; the state stays IDLE.
- IDLE with an aligned memory op:
  - Stall_o is 1 combinationally.
  - Address, funct3, byte offset, Wt_Addr and Wt_Enable are latched.
  - Next state is BUSY.
- BUSY:
  - Dmem_Req_o is 1 and Stall_o is 1.
  - Dmem_We_o, Addr, Be and Wdata come from the latched values.
  - The timeout counter increments every cycle.
  - On Dmem_Ack_i: load data is captured (extracted by byte offset, then sign- or zero-extended per funct3) and the next state is DONE.
  - Counter reaching TIMEOUT_CYC without an ack: Bus_Err_o is a 1-cycle pulse in the following DONE cycle, and the write is suppressed.
  - Ack and timeout in the same cycle: the ack wins.
- DONE (exactly one cycle):
  - Stall_o is 0 and Dmem_Req_o is 0.
  - Wt_Data_o is the captured load data; Wt_Addr_o and Wt_Enable_o are the latched values.
  - Stores force Wt_Enable_o to 0.
  - Next state is IDLE. Upstream advances on this edge, so the same instruction is never re-issued.
- Byte enables:
  - Byte access: 0001 << addr[1:0].
  - Half access: 0011 << addr[1:0].
  - Word access: 1111.
- Write data: the byte is replicated ×4, the half ×2, the word is passed as-is.
- Funct3 values 011, 110 and 111 are treated as word accesses.

## Timing
- Reset (asynchronous, active-low):
  - State goes to IDLE and the counter and all latches clear.
  - Dmem_Req_o, Dmem_We_o, Dmem_Be_o, Dmem_Addr_o and Dmem_Wdata_o are 0.
  - Stall_o, Misalign_o and Bus_Err_o are 0.
  - While in reset, Wt_Data_o, Wt_Addr_o and Wt_Enable_o are 0.
- Reset asserted mid-BUSY: Dmem_Req_o drops immediately, with no clock needed; the access is abandoned.
- Non-memory op: 0 added cycles.
- Memory op: 2 + N stall cycles, where N is the number of BUSY cycles before the ack (ack on the first BUSY cycle gives N = 0). The result appears to MEM_WB in DONE.
- Dmem_Req_o rises on the edge leaving IDLE and falls on the edge after the ack. The memory must not ack while Req is low; the stage ignores any such ack.
- Timeout: Bus_Err_o is high in the cycle after the counter reaches TIMEOUT_CYC.

## Test plan
- ALU op with Wt_Data_i=0x1234_5678, Wt_Addr_i=5, Wt_Enable_i=1 -> same values on the outputs that cycle; Stall_o=0; Dmem_Req_o never rises.
- LB at addr 0x103, memory returns 0x80FF_0000 with the ack on BUSY cycle 3 -> Dmem_Be_o=1000; Wt_Data_o=0xFFFF_FF80 in DONE; Stall_o high for 5 cycles total.
- LHU at addr 0x102, Rdata=0x8001_0000 with an immediate ack -> Wt_Data_o=0x0000_8001; SH at addr 0x102 with St_Data=0xAAAA_BEEF -> Be=1100, Wdata=0xBEEF_BEEF, Wt_Enable_o=0.
- LW at addr 0x101 -> Misalign_o=1 for one cycle; no Dmem_Req_o; Wt_Enable_o=0; Stall_o=0.
- TIMEOUT_CYC=4 with no ack -> Bus_Err_o pulses once; Wt_Enable_o=0; state back in IDLE; the next ALU op passes through.
- Reset pulled low on BUSY cycle 2 -> Dmem_Req_o=0 and Stall_o=0 at once; after release the stage is IDLE and a late ack is ignored.
